// File: rtl/face_pkg.sv
// Shared window geometry and FSM state encodings for the capture/scan
// sequencer and the face-detector window engine.
package face_pkg;

  localparam int IMG_ROWS       = 150;
  localparam int IMG_COLS       = 300;
  localparam int WIN            = 24;
  localparam int STRIDE         = 4;
  localparam int TIMEOUT_FRAMES = 4;

  // Largest origin that still keeps a whole window inside the image.
  function automatic int last_origin(input int dim, input int win, input int stride);
    return ((dim - win) / stride) * stride;
  endfunction

  localparam int LAST_ROW    = last_origin(IMG_ROWS, WIN, STRIDE);
  localparam int LAST_COL    = last_origin(IMG_COLS, WIN, STRIDE);
  localparam int N_WIN_ROWS  = LAST_ROW / STRIDE + 1;
  localparam int N_WIN_COLS  = LAST_COL / STRIDE + 1;
  localparam int WIN_COUNT   = N_WIN_ROWS * N_WIN_COLS;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ARM     = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;
  localparam logic [1:0] ST_SCAN    = 2'd3;

endpackage

// File: rtl/window_stepper.sv
// Raster-order window origin counters; last is registered alongside the
// origin so it always describes the origin currently presented.
module window_stepper #(
  parameter int IMG_ROWS = face_pkg::IMG_ROWS,
  parameter int IMG_COLS = face_pkg::IMG_COLS,
  parameter int WIN      = face_pkg::WIN,
  parameter int STRIDE   = face_pkg::STRIDE,
  parameter int RW       = $clog2(IMG_ROWS),
  parameter int CW       = $clog2(IMG_COLS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          step,
  output logic [RW-1:0] row,
  output logic [CW-1:0] col,
  output logic          last
);
  import face_pkg::*;

  localparam logic [RW-1:0] LR   = RW'(last_origin(IMG_ROWS, WIN, STRIDE));
  localparam logic [CW-1:0] LC   = CW'(last_origin(IMG_COLS, WIN, STRIDE));
  localparam logic [RW-1:0] RSTP = RW'(STRIDE);
  localparam logic [CW-1:0] CSTP = CW'(STRIDE);
  localparam logic          ONE_WIN = (LR == '0) && (LC == '0);

  logic [RW-1:0] row_inc;
  logic [CW-1:0] col_inc;

  assign row_inc = row + RSTP;
  assign col_inc = col + CSTP;

  always_ff @(posedge clk) begin
    if (reset) begin
      row  <= '0;
      col  <= '0;
      last <= 1'b0;
    end else if (clear) begin
      row  <= '0;
      col  <= '0;
      last <= ONE_WIN;
    end else if (step) begin
      if (col == LC) begin
        col  <= '0;
        row  <= row_inc;
        last <= (row_inc == LR) && (LC == '0);
      end else begin
        col  <= col_inc;
        last <= (row == LR) && (col_inc == LC);
      end
    end
  end

endmodule

// File: rtl/capture_scan_sequencer.sv
// Arms ImageRead at a frame boundary, waits for dataready, then issues every
// window origin of the captured frame to the detector over valid/ready.
module capture_scan_sequencer #(
  parameter int IMG_ROWS       = face_pkg::IMG_ROWS,
  parameter int IMG_COLS       = face_pkg::IMG_COLS,
  parameter int WIN            = face_pkg::WIN,
  parameter int STRIDE         = face_pkg::STRIDE,
  parameter int TIMEOUT_FRAMES = face_pkg::TIMEOUT_FRAMES
) (
  input  logic                        pixclk,
  input  logic                        RESET,
  input  logic [9:0]                  vsync,
  input  logic                        run,
  input  logic                        single,
  output logic                        cansend,
  input  logic                        dataready,
  output logic                        win_valid,
  input  logic                        win_ready,
  output logic [$clog2(IMG_ROWS)-1:0] win_row,
  output logic [$clog2(IMG_COLS)-1:0] win_col,
  output logic                        win_last,
  output logic                        busy,
  output logic                        scan_done,
  output logic                        timeout_err,
  output logic [7:0]                  drop_cnt
);
  import face_pkg::*;

  localparam int FC_W = $clog2(TIMEOUT_FRAMES + 1);
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(TIMEOUT_FRAMES - 1);

  logic [1:0]      state, state_nxt;
  logic [9:0]      vsync_q;
  logic            fs;
  logic            oneshot;
  logic [FC_W-1:0] frame_cnt;
  logic            hs, final_hs, timeout;

  assign fs       = (vsync == '0) && (vsync_q != '0);
  assign hs       = win_valid && win_ready;
  assign final_hs = hs && win_last;
  // dataready takes priority over a coincident frame start.
  assign timeout  = (state == ST_CAPTURE) && !dataready && fs && (frame_cnt == FC_LAST);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (run || single || oneshot) state_nxt = ST_ARM;
      ST_ARM:     if (fs) state_nxt = ST_CAPTURE;
      ST_CAPTURE: if (dataready) state_nxt = ST_SCAN;
                  else if (timeout) state_nxt = ST_IDLE;
      ST_SCAN:    if (final_hs) state_nxt = run ? ST_ARM : ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge pixclk) begin
    if (RESET) begin
      state       <= ST_IDLE;
      vsync_q     <= '0;
      oneshot     <= 1'b0;
      frame_cnt   <= '0;
      cansend     <= 1'b0;
      win_valid   <= 1'b0;
      busy        <= 1'b0;
      scan_done   <= 1'b0;
      timeout_err <= 1'b0;
      drop_cnt    <= '0;
    end else begin
      state     <= state_nxt;
      vsync_q   <= vsync;
      cansend   <= (state_nxt == ST_CAPTURE);
      win_valid <= (state_nxt == ST_SCAN);
      busy      <= (state_nxt != ST_IDLE);
      scan_done <= final_hs;

      if (state_nxt == ST_IDLE && state != ST_IDLE) oneshot <= 1'b0;
      else if (single)                              oneshot <= 1'b1;

      if (state != ST_CAPTURE)   frame_cnt <= '0;
      else if (fs && !dataready) frame_cnt <= frame_cnt + 1'b1;

      if (timeout) timeout_err <= 1'b1;

      if (state == ST_SCAN && fs && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
  end

  // Origin counters sit at (0,0) whenever not scanning.
  window_stepper #(
    .IMG_ROWS(IMG_ROWS), .IMG_COLS(IMG_COLS), .WIN(WIN), .STRIDE(STRIDE)
  ) u_stepper (
    .clk   (pixclk),
    .reset (RESET),
    .clear (state_nxt != ST_SCAN),
    .step  (hs),
    .row   (win_row),
    .col   (win_col),
    .last  (win_last)
  );

endmodule

// File: tb/tb_capture_scan_sequencer.sv
// Directed bench for capture_scan_sequencer: capture, full scan, backpressure,
// timeout, run-mode drops and mid-scan reset.
module tb_capture_scan_sequencer;

  logic       pixclk = 1'b0;
  logic       RESET = 1'b1;
  logic [9:0] vsync = '0;
  logic       run = 1'b0, single = 1'b0, dataready = 1'b0, win_ready = 1'b0;
  logic       cansend, win_valid, win_last, busy, scan_done, timeout_err;
  logic [7:0] win_row;
  logic [8:0] win_col;
  logic [7:0] drop_cnt;

  int checks = 0;
  int errors = 0;

  always #5 pixclk = ~pixclk;

  capture_scan_sequencer dut (
    .pixclk(pixclk), .RESET(RESET), .vsync(vsync), .run(run), .single(single),
    .cansend(cansend), .dataready(dataready), .win_valid(win_valid),
    .win_ready(win_ready), .win_row(win_row), .win_col(win_col),
    .win_last(win_last), .busy(busy), .scan_done(scan_done),
    .timeout_err(timeout_err), .drop_cnt(drop_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge pixclk);
    @(negedge pixclk);
  endtask

  task automatic frame_start;
    vsync = 10'd200; tick;
    vsync = 10'd0;   tick;
  endtask

  task automatic pulse_single;
    single = 1'b1; tick; single = 1'b0;
  endtask

  task automatic pulse_dataready;
    dataready = 1'b1; tick; dataready = 1'b0;
  endtask

  task automatic chk_reset_vals(input string p);
    chk({p, "_cansend"},   32'(cansend),     0);
    chk({p, "_valid"},     32'(win_valid),   0);
    chk({p, "_row"},       32'(win_row),     0);
    chk({p, "_col"},       32'(win_col),     0);
    chk({p, "_last"},      32'(win_last),    0);
    chk({p, "_busy"},      32'(busy),        0);
    chk({p, "_done"},      32'(scan_done),   0);
    chk({p, "_timeout"},   32'(timeout_err), 0);
    chk({p, "_drop"},      32'(drop_cnt),    0);
  endtask

  initial begin
    int idx, cyc;
    repeat (10) tick;
    chk_reset_vals("rst");
    RESET = 1'b0;
    tick;

    // dataready outside CAPTURE must not start anything
    pulse_dataready;
    chk("idle_dr_busy",  32'(busy),      0);
    chk("idle_dr_valid", 32'(win_valid), 0);

    // basic capture
    pulse_single;
    chk("arm_busy",    32'(busy),    1);
    chk("arm_cansend", 32'(cansend), 0);
    frame_start;
    chk("cap_cansend", 32'(cansend), 1);
    pulse_dataready;
    chk("scan_cansend", 32'(cansend),   0);
    chk("scan_valid",   32'(win_valid), 1);

    // full scan, back-to-back
    win_ready = 1'b1;
    for (int r = 0; r <= 124; r += 4)
      for (int c = 0; c <= 276; c += 4) begin
        chk("full_valid", 32'(win_valid), 1);
        chk("full_row",   32'(win_row),   32'(r));
        chk("full_col",   32'(win_col),   32'(c));
        chk("full_last",  32'(win_last),  32'(r == 124 && c == 276));
        tick;
      end
    chk("full_end_valid", 32'(win_valid), 0);
    chk("full_end_done",  32'(scan_done), 1);
    chk("full_end_busy",  32'(busy),      0);
    tick;
    chk("full_done_pulse", 32'(scan_done), 0);

    // fs coincident with dataready on the would-be timeout frame
    win_ready = 1'b0;
    pulse_single;
    frame_start;
    repeat (3) frame_start;
    chk("co_cansend", 32'(cansend), 1);
    vsync = 10'd200; tick;
    vsync = 10'd0; dataready = 1'b1; tick; dataready = 1'b0;
    chk("co_valid",   32'(win_valid),   1);
    chk("co_timeout", 32'(timeout_err), 0);
    chk("co_cansend2", 32'(cansend),    0);

    // backpressure scan
    idx = 0; cyc = 0;
    while (idx < 2240 && cyc < 20000) begin
      chk("bp_valid", 32'(win_valid), 1);
      chk("bp_row",   32'(win_row),   32'((idx / 70) * 4));
      chk("bp_col",   32'(win_col),   32'((idx % 70) * 4));
      chk("bp_last",  32'(win_last),  32'(idx == 2239));
      win_ready = 1'($urandom_range(0, 1));
      tick;
      if (win_ready) idx++;
      cyc++;
    end
    chk("bp_count", 32'(idx), 2240);
    chk("bp_done",  32'(scan_done), 1);
    chk("bp_valid_end", 32'(win_valid), 0);
    win_ready = 1'b0;
    tick;

    // timeout after 4 frame starts in CAPTURE
    pulse_single;
    frame_start;
    chk("to_cansend0", 32'(cansend), 1);
    repeat (3) frame_start;
    chk("to_cansend3", 32'(cansend),     1);
    chk("to_err3",     32'(timeout_err), 0);
    frame_start;
    chk("to_err",     32'(timeout_err), 1);
    chk("to_cansend", 32'(cansend),     0);
    chk("to_busy",    32'(busy),        0);

    // run mode with drops during SCAN
    run = 1'b1;
    tick;
    chk("run_busy", 32'(busy), 1);
    frame_start;
    chk("run_cansend", 32'(cansend), 1);
    pulse_dataready;
    chk("run_valid", 32'(win_valid), 1);
    win_ready = 1'b1;
    for (int i = 0; i < 2240; i++) begin
      vsync = (i == 10 || i == 50 || i == 90) ? 10'd200 : 10'd0;
      chk("run_row", 32'(win_row), 32'((i / 70) * 4));
      chk("run_col", 32'(win_col), 32'((i % 70) * 4));
      tick;
    end
    vsync = 10'd0;
    chk("run_drop",  32'(drop_cnt),  3);
    chk("run_done",  32'(scan_done), 1);
    chk("run_rearm", 32'(busy),      1);
    chk("run_valid_end", 32'(win_valid), 0);
    run = 1'b0;
    frame_start;
    chk("recap_cansend", 32'(cansend), 1);
    pulse_dataready;
    chk("recap_valid", 32'(win_valid), 1);
    chk("recap_row",   32'(win_row),   0);

    // mid-scan reset at window 100
    repeat (100) tick;
    chk("w100_row", 32'(win_row), 4);
    chk("w100_col", 32'(win_col), 120);
    RESET = 1'b1;
    tick;
    chk_reset_vals("midrst");
    RESET = 1'b0;
    tick;
    chk("post_rst_busy", 32'(busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
